// File: rtl/axi_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_arb_pkg                                                          |
// | Shared types and helpers for the AXI read-channel arbiter.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axi_arb_pkg;

  localparam int ARB_TAG_W  = 2;
  localparam int ARB_ID_W   = 16;
  localparam int ARB_ADDR_W = 64;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_ID_W-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
  } ar_req_t;

  // The source port tag rides in the low ID bits.
  function automatic logic [ARB_TAG_W-1:0] tag_of(input logic [ARB_ID_W-1:0] id);
    return id[ARB_TAG_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | N-way rotating-priority grant; search starts one past the last win. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     elig,
  input  logic             load,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  always_comb begin
    w_any  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N);
      if (!w_any && elig[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
  end

  assign any       = w_any;
  assign grant_idx = w_idx;
  assign grant     = w_any ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;

  // Reset to the highest index so port 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last <= IDX_W'(N-1);
    else if (load && w_any)
      r_last <= w_idx;
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_rd_arb                                                           |
// | Round-robin AR/R merge of several read masters onto one AXI port.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_rd_arb
  import axi_arb_pkg::*;
#(
  parameter int N_PORTS   = 3,
  parameter int SEL_W     = ARB_TAG_W,
  parameter int ID_W      = ARB_ID_W,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        s_arvalid,
  output logic [N_PORTS-1:0]        s_arready,
  input  logic [N_PORTS*ADDR_W-1:0] s_araddr,
  input  logic [N_PORTS*ID_W-1:0]   s_arid,
  input  logic [N_PORTS*8-1:0]      s_arlen,
  input  logic [N_PORTS*3-1:0]      s_arsize,
  output logic [N_PORTS-1:0]        s_rvalid,
  input  logic [N_PORTS-1:0]        s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [ID_W-1:0]           s_rid,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [ID_W-1:0]           m_arid,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  output logic                      err_bad_rid,
  output logic                      err_underflow
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int CW1   = CNT_W + 1;

  logic               r_full;
  ar_req_t            r_req;
  logic [N_PORTS-1:0] w_elig;
  logic [N_PORTS-1:0] w_grant;
  logic [SEL_W-1:0]   w_gidx;
  logic               w_any;
  logic               w_accept;
  logic               w_load;
  logic [SEL_W-1:0]   w_pend_tag;
  logic [SEL_W-1:0]   w_tag;
  logic               w_tag_ok;
  logic               w_rready;
  logic [N_PORTS-1:0] w_underflow;
  logic [N_PORTS-1:0] w_unused_id;
  logic               r_err_bad_rid;
  logic               r_err_underflow;

  logic [ADDR_W-1:0]  w_sel_addr;
  logic [ID_W-1:0]    w_sel_id;
  logic [7:0]         w_sel_len;
  logic [2:0]         w_sel_size;

  assign w_accept   = r_full & m_arready;
  assign w_load     = !r_full | m_arready;
  assign w_pend_tag = r_req.id[SEL_W-1:0];

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (SEL_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .elig      (w_elig),
    .load      (w_load),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  assign w_sel_addr = s_araddr[int'(w_gidx)*ADDR_W +: ADDR_W];
  assign w_sel_id   = {s_arid[int'(w_gidx)*ID_W +: ID_W-SEL_W], w_gidx};
  assign w_sel_len  = s_arlen[int'(w_gidx)*8 +: 8];
  assign w_sel_size = s_arsize[int'(w_gidx)*3 +: 3];

  assign s_arready = w_grant & {N_PORTS{w_load & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (w_load) begin
      r_full <= w_any;
      if (w_any)
        r_req <= '{addr: w_sel_addr, id: w_sel_id, len: w_sel_len, size: w_sel_size};
    end
  end

  assign m_arvalid = r_full;
  assign m_araddr  = r_req.addr;
  assign m_arid    = r_req.id;
  assign m_arlen   = r_req.len;
  assign m_arsize  = r_req.size;

  assign w_tag    = SEL_W'(tag_of(ARB_ID_W'(m_rid)));
  assign w_tag_ok = int'(w_tag) < N_PORTS;

  // Unknown tags are sunk so a stray beat cannot wedge the shared R channel.
  always_comb begin
    w_rready = 1'b1;
    for (int i = 0; i < N_PORTS; i++)
      if (w_tag == SEL_W'(i))
        w_rready = s_rready[i];
  end

  assign m_rready = rst_n & w_rready;
  assign s_rdata  = m_rdata;
  assign s_rid    = {{SEL_W{1'b0}}, m_rid[ID_W-1:SEL_W]};
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic [CNT_W-1:0] r_outst;
    logic             w_pend;
    logic             w_inc;
    logic             w_dec;

    // A request parked in the AR register already occupies a slot.
    assign w_pend    = r_full & (w_pend_tag == SEL_W'(i));
    assign w_elig[i] = s_arvalid[i] &
                       ((CW1'(r_outst) + CW1'(w_pend)) < CW1'(MAX_OUTST));
    assign w_inc     = w_accept & w_pend;
    assign w_dec     = m_rvalid & m_rready & m_rlast & w_tag_ok & (w_tag == SEL_W'(i));
    assign w_underflow[i] = w_dec & (r_outst == '0);
    assign s_rvalid[i]    = rst_n & m_rvalid & (w_tag == SEL_W'(i));
    assign w_unused_id[i] = ^s_arid[i*ID_W + ID_W - 1 -: SEL_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_outst <= '0;
      else if (w_inc && !w_dec)
        r_outst <= r_outst + 1'b1;
      else if (w_dec && !w_inc && r_outst != '0)
        r_outst <= r_outst - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_bad_rid   <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (m_rvalid && !w_tag_ok)
        r_err_bad_rid <= 1'b1;
      if (|w_underflow)
        r_err_underflow <= 1'b1;
    end
  end

  assign err_bad_rid   = r_err_bad_rid;
  assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_rd_arb                                                        |
// | Scoreboard bench for the round-robin AXI read arbiter.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axi_rd_arb;

  localparam int NP = 3;
  localparam int SW = 2;
  localparam int IW = 16;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int MO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NP-1:0]  s_arvalid = '0;
  logic [NP-1:0]  s_arready;
  logic [NP*AW-1:0] s_araddr = '0;
  logic [NP*IW-1:0] s_arid = '0;
  logic [NP*8-1:0]  s_arlen = '0;
  logic [NP*3-1:0]  s_arsize = '0;
  logic [NP-1:0]  s_rvalid;
  logic [NP-1:0]  s_rready = '0;
  logic [DW-1:0]  s_rdata;
  logic [IW-1:0]  s_rid;
  logic [1:0]     s_rresp;
  logic           s_rlast;
  logic           m_arvalid;
  logic           m_arready = 1'b0;
  logic [AW-1:0]  m_araddr;
  logic [IW-1:0]  m_arid;
  logic [7:0]     m_arlen;
  logic [2:0]     m_arsize;
  logic           m_rvalid = 1'b0;
  logic           m_rready;
  logic [DW-1:0]  m_rdata = '0;
  logic [IW-1:0]  m_rid = '0;
  logic [1:0]     m_rresp = '0;
  logic           m_rlast = 1'b0;
  logic           err_bad_rid;
  logic           err_underflow;

  always #5 clk = ~clk;

  axi_rd_arb #(
    .N_PORTS(NP), .SEL_W(SW), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .err_bad_rid(err_bad_rid), .err_underflow(err_underflow)
  );

  typedef struct {
    logic [63:0] addr;
    logic [15:0] id;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct {
    logic [2:0]  rvalid;
    logic        rready;
    logic [15:0] rid;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int      grant_q[$];
  ar_exp_t mon_ar;
  r_exp_t  mon_r;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] port_addr(input int p);
    return 64'hA000 + 64'(p) * 64'h100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ar_q.delete();
      r_q.delete();
    end else begin
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) begin
          check_val("ar_unexpected", 64'd1, 64'd0);
        end else begin
          mon_ar = ar_q.pop_front();
          check_val("m_araddr", m_araddr, mon_ar.addr);
          check_val("m_arid", 64'(m_arid), 64'(mon_ar.id));
          check_val("m_arlen", 64'(m_arlen), 64'(mon_ar.len));
          check_val("m_arsize", 64'(m_arsize), 64'(mon_ar.size));
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (s_arvalid[i] && s_arready[i]) begin
          mon_ar.addr = port_addr(i);
          mon_ar.id   = {s_arid[i*IW +: IW-SW], SW'(i)};
          mon_ar.len  = 8'(i + 1);
          mon_ar.size = 3'd6;
          ar_q.push_back(mon_ar);
          grant_q.push_back(i);
        end
      end
      if (m_rvalid) begin
        if (r_q.size() == 0) begin
          check_val("r_unexpected", 64'd1, 64'd0);
        end else begin
          mon_r = r_q.pop_front();
          check_val("s_rvalid", 64'(s_rvalid), 64'(mon_r.rvalid));
          check_val("m_rready", 64'(m_rready), 64'(mon_r.rready));
          check_val("s_rid", 64'(s_rid), 64'(mon_r.rid));
          check_val("s_rdata", s_rdata[63:0], mon_r.data);
          check_val("s_rresp", 64'(s_rresp), 64'(mon_r.resp));
          check_val("s_rlast", 64'(s_rlast), 64'(mon_r.last));
        end
      end
    end
  end

  task automatic send_r(input logic [1:0] tag, input logic [13:0] pay,
                        input logic last, input logic [2:0] rdy);
    r_exp_t e;
    e.rvalid = (int'(tag) < NP) ? 3'(1 << tag) : 3'b000;
    e.rready = (int'(tag) < NP) ? rdy[tag] : 1'b1;
    e.rid    = {2'b00, pay};
    e.data   = {48'h0, pay, tag};
    e.resp   = pay[1:0];
    e.last   = last;
    r_q.push_back(e);
    m_rvalid = 1'b1;
    m_rid    = {pay, tag};
    m_rdata  = {8{48'h0, pay, tag}};
    m_rresp  = pay[1:0];
    m_rlast  = last;
    s_rready = rdy;
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    s_arvalid = '0;
    m_rvalid  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input int p, input int n, output int got);
    got = 0;
    s_arvalid[p] = 1'b1;
    for (int c = 0; c < 40 && got < n; c++) begin
      #1;
      if (s_arvalid[p] && s_arready[p]) got++;
      tick();
    end
    s_arvalid[p] = 1'b0;
  endtask

  int got;
  int hs;
  int cnt [NP];
  int seen;

  initial begin
    for (int i = 0; i < NP; i++) begin
      s_araddr[i*AW +: AW] = port_addr(i);
      s_arid[i*IW +: IW]   = 16'h0015;
      s_arlen[i*8 +: 8]    = 8'(i + 1);
      s_arsize[i*3 +: 3]   = 3'd6;
    end

    // Reset state with every port requesting.
    s_arvalid = 3'b111;
    m_arready = 1'b1;
    repeat (3) tick();
    check_val("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check_val("rst_s_arready", 64'(s_arready), 64'd0);
    check_val("rst_m_rready", 64'(m_rready), 64'd0);
    check_val("rst_errs", 64'({err_bad_rid, err_underflow}), 64'd0);
    grant_q.delete();
    rst_n = 1'b1;

    // Fair rotation 0,1,2,0,1,2.
    repeat (6) tick();
    s_arvalid = '0;
    check_val("t1_grant_count", 64'(grant_q.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      check_val("t1_grant", 64'(grant_q.size() > k ? grant_q[k] : -1), 64'(k % 3));
    repeat (2) tick();
    check_val("t1_drained", 64'(ar_q.size()), 64'd0);

    // Stall with a request loaded.
    s_arvalid = 3'b011;
    m_arready = 1'b0;
    #1;
    check_val("t2_first_grant", 64'(s_arready), 64'b001);
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check_val("t2_stall_valid", 64'(m_arvalid), 64'd1);
      check_val("t2_stall_addr", m_araddr, port_addr(0));
      check_val("t2_stall_id", 64'(m_arid), 64'h0054);
      check_val("t2_stall_ready", 64'(s_arready), 64'd0);
      tick();
    end
    m_arready = 1'b1;
    #1;
    check_val("t2_release_grant", 64'(s_arready), 64'b010);
    tick();
    s_arvalid = '0;
    repeat (2) tick();

    // Outstanding limit on port 1.
    do_reset();
    m_arready = 1'b1;
    s_arvalid = 3'b010;
    hs = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s_arready[1]) hs++;
      tick();
    end
    check_val("t3_port1_limit", 64'(hs), 64'(MO));
    s_arvalid = 3'b111;
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      for (int i = 0; i < NP; i++) if (s_arready[i]) cnt[i]++;
      tick();
    end
    check_val("t3_port0_grants", 64'(cnt[0]), 64'd4);
    check_val("t3_port1_grants", 64'(cnt[1]), 64'd0);
    check_val("t3_port2_grants", 64'(cnt[2]), 64'd4);
    s_arvalid = 3'b010;
    send_r(2'd1, 14'h00AB, 1'b1, 3'b010);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (s_arready[1]) seen = 1;
      tick();
    end
    check_val("t3_regrant", 64'(seen), 64'd1);
    s_arvalid = '0;
    repeat (2) tick();

    // Interleaved routing with port 0 back-pressuring.
    send_r(2'd2, 14'h0101, 1'b0, 3'b110);
    send_r(2'd0, 14'h0202, 1'b0, 3'b110);
    send_r(2'd1, 14'h0303, 1'b0, 3'b110);
    check_val("t4_no_bad_rid", 64'(err_bad_rid), 64'd0);

    // Bad tag is sunk and flagged stickily.
    send_r(2'd3, 14'h03FF, 1'b0, 3'b000);
    check_val("t5_bad_rid_set", 64'(err_bad_rid), 64'd1);
    repeat (3) tick();
    check_val("t5_bad_rid_sticky", 64'(err_bad_rid), 64'd1);
    check_val("t5_no_underflow", 64'(err_underflow), 64'd0);

    // Reset mid-burst with counts 4/2/0.
    do_reset();
    check_val("t6_bad_rid_cleared", 64'(err_bad_rid), 64'd0);
    m_arready = 1'b1;
    issue(0, 4, got);
    check_val("t6_issue0", 64'(got), 64'd4);
    issue(1, 2, got);
    check_val("t6_issue1", 64'(got), 64'd2);
    repeat (2) tick();
    s_arvalid = 3'b111;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rid     = 16'h0010;
    m_rlast   = 1'b0;
    s_rready  = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_arready", 64'(s_arready), 64'd0);
    check_val("t6_async_rvalid", 64'(s_rvalid), 64'd0);
    check_val("t6_async_rready", 64'(m_rready), 64'd0);
    check_val("t6_async_arvalid", 64'(m_arvalid), 64'd0);
    check_val("t6_async_araddr", m_araddr, 64'd0);
    tick();
    tick();
    m_rvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_val("t6_first_grant", 64'(s_arready), 64'b001);
    s_arvalid = '0;
    tick();
    send_r(2'd1, 14'h0044, 1'b1, 3'b010);
    check_val("t6_underflow", 64'(err_underflow), 64'd1);
    m_arready = 1'b1;
    s_arvalid = 3'b010;
    hs = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s_arready[1]) hs++;
      tick();
    end
    check_val("t6_port1_from_zero", 64'(hs), 64'(MO));
    s_arvalid = '0;
    repeat (3) tick();
    check_val("end_ar_queue", 64'(ar_q.size()), 64'd0);
    check_val("end_r_queue", 64'(r_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
